// File: rtl/s2mm_writer.sv
// s2mm_writer: buffers a 32-bit AXI4-Stream into a word FIFO and writes it out as AXI4 INCR bursts.
// Define S2MM_TLAST_CHECK_EN to flag tlast positions that disagree with the programmed length.
module s2mm_writer #(
  parameter int FIFO_DEPTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic        m_axi_s2mm_aclk,
  input  logic        axi_resetn,
  input  logic        s2mm_start,
  input  logic [31:0] s2mm_dmacr,
  input  logic [31:0] s2mm_da,
  input  logic [31:0] s2mm_length,
  input  logic [31:0] s_axis_s2mm_tdata,
  input  logic [3:0]  s_axis_s2mm_tkeep,
  input  logic        s_axis_s2mm_tlast,
  input  logic        s_axis_s2mm_tvalid,
  output logic        s_axis_s2mm_tready,
  output logic [31:0] m_axi_s2mm_awaddr,
  output logic [7:0]  m_axi_s2mm_awlen,
  output logic [2:0]  m_axi_s2mm_awsize,
  output logic [1:0]  m_axi_s2mm_awburst,
  output logic [3:0]  m_axi_s2mm_awcache,
  output logic [2:0]  m_axi_s2mm_awprot,
  output logic        m_axi_s2mm_awvalid,
  input  logic        m_axi_s2mm_awready,
  output logic [31:0] m_axi_s2mm_wdata,
  output logic [3:0]  m_axi_s2mm_wstrb,
  output logic        m_axi_s2mm_wlast,
  output logic        m_axi_s2mm_wvalid,
  input  logic        m_axi_s2mm_wready,
  input  logic [1:0]  m_axi_s2mm_bresp,
  input  logic        m_axi_s2mm_bvalid,
  output logic        m_axi_s2mm_bready,
  output logic        s2mm_busy,
  output logic        s2mm_done,
  output logic        s2mm_err,
  output logic        s2mm_tlast_err,
  output logic        s2mm_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [24:0]   remaining_q, remaining_d, total_q, total_d, accepted_q, accepted_d;
  logic [1:0]    tail_q, tail_d;
  logic [8:0]    burst_q, burst_d, beat_q, beat_d;
  logic [7:0]    awlen_q, awlen_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d, bready_q, bready_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d, tlast_err_q, tlast_err_d, irq_q, irq_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   mem [FIFO_DEPTH];

  logic          push, pop, last_burst;
  logic [10:0]   words_4k;
  logic [8:0]    burst_calc;
  logic [24:0]   b_tmp;
  logic [26:0]   len_plus;
  logic [24:0]   total_w;

  function automatic logic [3:0] tail_strb(input logic [1:0] t);
    case (t)
      2'd1:    return 4'h1;
      2'd2:    return 4'h3;
      2'd3:    return 4'h7;
      default: return 4'hF;
    endcase
  endfunction

  assign s_axis_s2mm_tready = busy_q && (count_q != CNT_FULL) && (accepted_q < total_q);
  assign push       = s_axis_s2mm_tvalid && s_axis_s2mm_tready;
  assign pop        = wvalid_q && m_axi_s2mm_wready;
  assign last_burst = (remaining_q == 25'(burst_q));
  assign len_plus   = {1'b0, s2mm_length[25:0]} + 27'd3;
  assign total_w    = len_plus[26:2];
  assign words_4k   = 11'd1024 - 11'(addr_q[11:2]);

  // Beats for the next burst: capped by MAX_BURST, words left, and the 4 KB page end.
  always_comb begin
    b_tmp = 25'(MAX_BURST);
    if (remaining_q < b_tmp) b_tmp = remaining_q;
    if (25'(words_4k) < b_tmp) b_tmp = 25'(words_4k);
    burst_calc = b_tmp[8:0];
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch below can leave a latch behind.
    state_d = state_q;         addr_d = addr_q;         remaining_d = remaining_q;
    total_d = total_q;         accepted_d = accepted_q; tail_d = tail_q;
    burst_d = burst_q;         beat_d = beat_q;         awlen_d = awlen_q;
    wstrb_d = wstrb_q;         awvalid_d = awvalid_q;   wvalid_d = wvalid_q;
    wlast_d = wlast_q;         bready_d = bready_q;     busy_d = busy_q;
    done_d = done_q;           err_d = err_q;           tlast_err_d = tlast_err_q;
    irq_d = 1'b0;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CNT_ONE;
    if (pop && !push) count_d = count_q - CNT_ONE;
    if (push) accepted_d = accepted_q + 25'd1;
`ifdef S2MM_TLAST_CHECK_EN
    if (push && (s_axis_s2mm_tlast != (accepted_q + 25'd1 == total_q))) tlast_err_d = 1'b1;
`endif

    unique case (state_q)
      IDLE: begin
        if (s2mm_start && s2mm_dmacr[0]) begin
          addr_d      = {s2mm_da[31:2], 2'b00};
          remaining_d = total_w;
          total_d     = total_w;
          tail_d      = s2mm_length[1:0];
          accepted_d  = '0;
          err_d       = 1'b0;
          tlast_err_d = 1'b0;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          count_d     = '0;
          if (total_w == '0) begin
            done_d = 1'b1;
            irq_d  = s2mm_dmacr[12];
          end else begin
            done_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        if (awvalid_q) begin
          if (m_axi_s2mm_awready) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b1;
            beat_d    = '0;
            wlast_d   = (burst_q == 9'd1);
            wstrb_d   = (last_burst && burst_q == 9'd1) ? tail_strb(tail_q) : 4'hF;
            state_d   = DATA;
          end
        end else if (32'(count_q) >= 32'(burst_calc)) begin
          // The whole burst is already buffered, so wvalid never drops mid-burst.
          awvalid_d = 1'b1;
          awlen_d   = 8'(burst_calc - 9'd1);
          burst_d   = burst_calc;
        end
      end
      DATA: begin
        if (m_axi_s2mm_wready) begin
          beat_d = beat_q + 9'd1;
          if (wlast_q) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            wstrb_d  = 4'h0;
            bready_d = 1'b1;
            state_d  = RESP;
          end else begin
            wlast_d = (beat_q + 9'd2 == burst_q);
            wstrb_d = (last_burst && beat_q + 9'd2 == burst_q) ? tail_strb(tail_q) : 4'hF;
          end
        end
      end
      RESP: begin
        if (m_axi_s2mm_bvalid) begin
          bready_d    = 1'b0;
          if (m_axi_s2mm_bresp != 2'b00) err_d = 1'b1;
          addr_d      = addr_q + {21'd0, burst_q, 2'b00};
          remaining_d = remaining_q - 25'(burst_q);
          if (last_burst) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            irq_d   = s2mm_dmacr[12];
          end else if (!s2mm_dmacr[0]) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
          end else begin
            state_d = ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from the same old values.
  always_ff @(posedge m_axi_s2mm_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q <= IDLE;   addr_q <= '0;    remaining_q <= '0; total_q <= '0;
      accepted_q <= '0;  tail_q <= '0;    burst_q <= '0;     beat_q <= '0;
      awlen_q <= '0;     wstrb_q <= '0;   awvalid_q <= 1'b0; wvalid_q <= 1'b0;
      wlast_q <= 1'b0;   bready_q <= 1'b0; busy_q <= 1'b0;   done_q <= 1'b0;
      err_q <= 1'b0;     tlast_err_q <= 1'b0; irq_q <= 1'b0;
      wr_ptr_q <= '0;    rd_ptr_q <= '0;  count_q <= '0;
    end else begin
      state_q <= state_d; addr_q <= addr_d; remaining_q <= remaining_d; total_q <= total_d;
      accepted_q <= accepted_d; tail_q <= tail_d; burst_q <= burst_d; beat_q <= beat_d;
      awlen_q <= awlen_d; wstrb_q <= wstrb_d; awvalid_q <= awvalid_d; wvalid_q <= wvalid_d;
      wlast_q <= wlast_d; bready_q <= bready_d; busy_q <= busy_d; done_q <= done_d;
      err_q <= err_d; tlast_err_q <= tlast_err_d; irq_q <= irq_d;
      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; count_q <= count_d;
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge m_axi_s2mm_aclk) begin
    if (push) mem[wr_ptr_q] <= s_axis_s2mm_tdata;
  end

  assign m_axi_s2mm_awaddr  = addr_q;
  assign m_axi_s2mm_awlen   = awlen_q;
  assign m_axi_s2mm_awsize  = 3'b010;
  assign m_axi_s2mm_awburst = 2'b01;
  assign m_axi_s2mm_awcache = 4'b0011;
  assign m_axi_s2mm_awprot  = 3'b000;
  assign m_axi_s2mm_awvalid = awvalid_q;
  assign m_axi_s2mm_wdata   = wvalid_q ? mem[rd_ptr_q] : 32'h0;
  assign m_axi_s2mm_wstrb   = wstrb_q;
  assign m_axi_s2mm_wlast   = wlast_q;
  assign m_axi_s2mm_wvalid  = wvalid_q;
  assign m_axi_s2mm_bready  = bready_q;
  assign s2mm_busy          = busy_q;
  assign s2mm_done          = done_q;
  assign s2mm_err           = err_q;
  assign s2mm_tlast_err     = tlast_err_q;
  assign s2mm_irq           = irq_q;

  logic unused_inputs;
`ifdef S2MM_TLAST_CHECK_EN
  assign unused_inputs = ^{s_axis_s2mm_tkeep, s2mm_dmacr[31:13], s2mm_dmacr[11:1],
                           s2mm_da[1:0], s2mm_length[31:26]};
`else
  assign unused_inputs = ^{s_axis_s2mm_tkeep, s2mm_dmacr[31:13], s2mm_dmacr[11:1],
                           s2mm_da[1:0], s2mm_length[31:26], s_axis_s2mm_tlast};
`endif
endmodule

// File: tb/tb_s2mm_writer.sv
// Directed bench for s2mm_writer: stream driver, AXI write slave with a beat recorder, and hand-computed expectations.
module tb_s2mm_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s2mm_start = 1'b0;
  logic [31:0] s2mm_dmacr = '0, s2mm_da = '0, s2mm_length = '0;
  logic [31:0] tdata = '0;
  logic [3:0]  tkeep = 4'hF;
  logic        tlast = 1'b0, tvalid = 1'b0, tready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst;
  logic [3:0]  awcache;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        busy, done, err, tlast_err, irq;

  always #5 clk = ~clk;

  s2mm_writer dut (
    .m_axi_s2mm_aclk(clk), .axi_resetn(rst_n), .s2mm_start(s2mm_start),
    .s2mm_dmacr(s2mm_dmacr), .s2mm_da(s2mm_da), .s2mm_length(s2mm_length),
    .s_axis_s2mm_tdata(tdata), .s_axis_s2mm_tkeep(tkeep), .s_axis_s2mm_tlast(tlast),
    .s_axis_s2mm_tvalid(tvalid), .s_axis_s2mm_tready(tready),
    .m_axi_s2mm_awaddr(awaddr), .m_axi_s2mm_awlen(awlen), .m_axi_s2mm_awsize(awsize),
    .m_axi_s2mm_awburst(awburst), .m_axi_s2mm_awcache(awcache), .m_axi_s2mm_awprot(awprot),
    .m_axi_s2mm_awvalid(awvalid), .m_axi_s2mm_awready(awready),
    .m_axi_s2mm_wdata(wdata), .m_axi_s2mm_wstrb(wstrb), .m_axi_s2mm_wlast(wlast),
    .m_axi_s2mm_wvalid(wvalid), .m_axi_s2mm_wready(wready),
    .m_axi_s2mm_bresp(bresp), .m_axi_s2mm_bvalid(bvalid), .m_axi_s2mm_bready(bready),
    .s2mm_busy(busy), .s2mm_done(done), .s2mm_err(err), .s2mm_tlast_err(tlast_err), .s2mm_irq(irq)
  );

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Recorded traffic for the current transfer
  logic [31:0] aw_addr[$];
  logic [7:0]  aw_len[$];
  logic [31:0] w_data[$];
  logic [3:0]  w_strb[$];
  bit          w_last[$];
  logic [1:0]  bresp_plan[$];
  int irq_cycles = 0, acc_cnt = 0, b_cnt = 0, overlap = 0, outstanding_viol = 0, stream_timeouts = 0;
  bit b_pending = 0, b_hs = 0, w_stall = 0;
  int cyc = 0;

  task automatic clear_mon();
    aw_addr.delete(); aw_len.delete(); w_data.delete(); w_strb.delete(); w_last.delete();
    irq_cycles = 0; acc_cnt = 0; b_cnt = 0;
  endtask

  // Monitor: inputs change just after posedge and outputs at posedge, so negedge values are what the next edge sees.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (awvalid && wvalid) overlap++;
      if (awvalid && awready) begin aw_addr.push_back(awaddr); aw_len.push_back(awlen); end
      if (wvalid && wready) begin
        w_data.push_back(wdata); w_strb.push_back(wstrb); w_last.push_back(wlast);
        if (wlast) b_pending = 1;
      end
      if (bvalid && bready) begin b_hs = 1; b_cnt++; end
      if (aw_addr.size() - b_cnt > 1) outstanding_viol++;
      if (irq) irq_cycles++;
      if (tvalid && tready) acc_cnt++;
    end
  end

  // AXI write slave
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0; b_pending = 0; b_hs = 0;
      end else begin
        awready = awvalid;
        wready  = wvalid && !w_stall && (cyc % 3 != 2);
        if (b_hs) begin
          bvalid = 0; b_hs = 0;
        end else if (b_pending && !bvalid) begin
          bvalid = 1;
          bresp  = (bresp_plan.size() > 0) ? bresp_plan.pop_front() : 2'b00;
          b_pending = 0;
        end
        cyc++;
      end
    end
  end

  task automatic start_xfer(input logic [31:0] da, input logic [31:0] len, input logic [31:0] cr);
    @(posedge clk); #1;
    s2mm_da = da; s2mm_length = len; s2mm_dmacr = cr; s2mm_start = 1;
    @(posedge clk); #1;
    s2mm_start = 0;
  endtask

  task automatic send_stream(input int n, input int tlast_pos, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      int guard;
      bit hs;
      guard = 0; hs = 0;
      tdata = base + i; tlast = (i + 1 == tlast_pos); tvalid = 1;
      while (!hs && guard < 2000) begin
        @(negedge clk); hs = tready;
        @(posedge clk); #1; guard++;
      end
      if (!hs) begin stream_timeouts++; break; end
    end
    tvalid = 0; tlast = 0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 5000) begin @(negedge clk); n++; end
    check({tag, " done reached"}, done, 1);
  endtask

  function automatic int data_errs(input logic [31:0] base);
    int e;
    e = 0;
    foreach (w_data[k]) if (w_data[k] !== base + k) e++;
    return e;
  endfunction

  function automatic int first_last();
    int idx;
    idx = -1;
    foreach (w_last[k]) if (w_last[k] && idx < 0) idx = k;
    return idx;
  endfunction

  function automatic int count_last();
    int c;
    c = 0;
    foreach (w_last[k]) if (w_last[k]) c++;
    return c;
  endfunction

  function automatic int strb_not_f(input int upto);
    int c;
    c = 0;
    foreach (w_strb[k]) if (k < upto && w_strb[k] != 4'hF) c++;
    return c;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy", busy, 0);
    check("rst awvalid", awvalid, 0);
    check("rst wvalid", wvalid, 0);
    check("rst tready", tready, 0);
    check("rst done", done, 0);
    check("rst awsize", awsize, 3'b010);
    check("rst awburst", awburst, 2'b01);
    check("rst awcache", awcache, 4'b0011);
    @(posedge clk); #1 rst_n = 1;

    // Single 16-beat burst
    clear_mon();
    start_xfer(32'h1000, 64, 32'h1);
    fork
      send_stream(16, 16, 32'hA000_0000);
      wait_done("t1");
    join
    repeat (3) @(negedge clk);
    check("t1 aw count", aw_addr.size(), 1);
    check("t1 awaddr", aw_addr[0], 32'h1000);
    check("t1 awlen", aw_len[0], 15);
    check("t1 beats", w_data.size(), 16);
    check("t1 data", data_errs(32'hA000_0000), 0);
    check("t1 strb", strb_not_f(16), 0);
    check("t1 wlast idx", first_last(), 15);
    check("t1 wlast count", count_last(), 1);
    check("t1 err", err, 0);
    check("t1 busy", busy, 0);
    check("t1 irq", irq_cycles, 0);

    // 4 KB boundary split
    clear_mon();
    start_xfer(32'h0FF8, 40, 32'h1);
    fork
      send_stream(10, 10, 32'hB000_0000);
      wait_done("t2");
    join
    repeat (3) @(negedge clk);
    check("t2 aw count", aw_addr.size(), 2);
    check("t2 awaddr0", aw_addr[0], 32'h0FF8);
    check("t2 awlen0", aw_len[0], 1);
    check("t2 awaddr1", aw_addr[1], 32'h1000);
    check("t2 awlen1", aw_len[1], 7);
    check("t2 beats", w_data.size(), 10);
    check("t2 data", data_errs(32'hB000_0000), 0);
    check("t2 burst2 first word", w_data[2], 32'hB000_0002);
    check("t2 wlast count", count_last(), 2);

    // Partial tail word and IRQ
    clear_mon();
    start_xfer(32'h4000, 7, 32'h1001);
    fork
      send_stream(2, 2, 32'hC000_0000);
      wait_done("t3");
    join
    repeat (3) @(negedge clk);
    check("t3 beats", w_data.size(), 2);
    check("t3 awlen", aw_len[0], 1);
    check("t3 strb0", w_strb[0], 4'hF);
    check("t3 strb1", w_strb[1], 4'h7);
    check("t3 irq cycles", irq_cycles, 1);

    // Error response on first burst, start while busy ignored
    clear_mon();
    bresp_plan.push_back(2'b10);
    bresp_plan.push_back(2'b00);
    start_xfer(32'h2000, 128, 32'h1);
    fork
      send_stream(32, 32, 32'hD000_0000);
      wait_done("t4");
      begin
        repeat (4) @(posedge clk); #1;
        s2mm_length = 4; s2mm_start = 1;
        @(posedge clk); #1;
        s2mm_start = 0; s2mm_length = 128;
        @(negedge clk);
        check("t4 busy after ignored start", busy, 1);
      end
    join
    repeat (3) @(negedge clk);
    check("t4 aw count", aw_addr.size(), 2);
    check("t4 awaddr1", aw_addr[1], 32'h2040);
    check("t4 awlen1", aw_len[1], 15);
    check("t4 beats", w_data.size(), 32);
    check("t4 data", data_errs(32'hD000_0000), 0);
    check("t4 accepted", acc_cnt, 32);
    check("t4 err", err, 1);

    // Zero length
    clear_mon();
    tvalid = 1; tdata = 32'h5555_5555;
    start_xfer(32'h5000, 0, 32'h1001);
    @(negedge clk);
    check("t5 done next cycle", done, 1);
    check("t5 busy", busy, 0);
    repeat (5) @(negedge clk);
    check("t5 accepted", acc_cnt, 0);
    check("t5 aw count", aw_addr.size(), 0);
    check("t5 irq cycles", irq_cycles, 1);
    tvalid = 0;

    // Reset asserted while in DATA
    clear_mon();
    w_stall = 1;
    start_xfer(32'h3000, 64, 32'h1);
    send_stream(16, 16, 32'hE000_0000);
    begin
      int n;
      n = 0;
      while (!wvalid && n < 200) begin @(negedge clk); n++; end
    end
    check("t6 reached data", wvalid, 1);
    #2 rst_n = 0;
    #1;
    check("t6 busy", busy, 0);
    check("t6 wvalid", wvalid, 0);
    check("t6 awvalid", awvalid, 0);
    check("t6 bready", bready, 0);
    check("t6 tready", tready, 0);
    check("t6 wdata", wdata, 0);
    check("t6 wstrb", wstrb, 0);
    check("t6 awaddr", awaddr, 0);
    check("t6 awlen", awlen, 0);
    @(posedge clk); #1 w_stall = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // tlast on word 3 of 8
    clear_mon();
    start_xfer(32'h6000, 32, 32'h1);
    fork
      send_stream(8, 3, 32'hF000_0000);
      wait_done("t7");
    join
    repeat (3) @(negedge clk);
    check("t7 beats", w_data.size(), 8);
    check("t7 data", data_errs(32'hF000_0000), 0);
`ifdef S2MM_TLAST_CHECK_EN
    check("t7 tlast_err", tlast_err, 1);
`else
    check("t7 tlast_err", tlast_err, 0);
`endif

    check("aw/w overlap cycles", overlap, 0);
    check("outstanding bursts", outstanding_viol, 0);
    check("stream timeouts", stream_timeouts, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
